// File: rtl/pmem_responder.sv
// Line-granular backing store that answers cache line read/write requests after a fixed latency.
// Optional protocol checking is built when PMEM_PROTOCOL_CHECK_EN is defined.
module pmem_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_BITS   = 128,
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  pmem_resp,
  output logic                  protocol_err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int WORDS = LINE_BITS / 16;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;
  logic                   resp_q, resp_d;

  logic                   req;
  logic                   enter_resp;
  logic                   mem_we;
  logic                   txn_wr;
  logic [IDX_W-1:0]       txn_idx;
  logic [LINE_BITS-1:0]   txn_wdata;
  logic [DEPTH_LINES-1:0][LINE_BITS-1:0] mem_rd;

  assign req = pmem_read | pmem_write;

  // With LATENCY=1 the array is touched on the acceptance edge itself, so the
  // transaction fields come straight from the inputs while IDLE.
  assign txn_wr    = (state_q == IDLE) ? pmem_write : op_wr_q;
  assign txn_idx   = (state_q == IDLE) ? pmem_address[IDX_W+3:4] : idx_q;
  assign txn_wdata = (state_q == IDLE) ? pmem_wdata : wdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          op_wr_d = pmem_write;
          idx_d   = pmem_address[IDX_W+3:4];
          wdata_d = pmem_wdata;
          cnt_d   = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_we = enter_resp & txn_wr;
    if (enter_resp && !txn_wr) begin
      rdata_d = mem_rd[txn_idx];
    end
    resp_d = enter_resp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  // Every line resets to its own byte addresses, so the array is flop based.
  for (genvar gi = 0; gi < DEPTH_LINES; gi++) begin : g_line
    logic [LINE_BITS-1:0] init_line;
    logic [LINE_BITS-1:0] line_q, line_d;

    for (genvar gj = 0; gj < WORDS; gj++) begin : g_word
      assign init_line[gj*16 +: 16] = 16'((gi << 4) | (gj << 1));
    end

    assign line_d     = (mem_we && (txn_idx == IDX_W'(gi))) ? txn_wdata : line_q;
    assign mem_rd[gi] = line_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) line_q <= init_line;
      else        line_q <= line_d;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic                  req_rd_q, req_rd_d;
  logic                  req_wr_q, req_wr_d;
  logic [ADDR_WIDTH-5:0] addr_hi_q, addr_hi_d;
  logic                  err_q, err_d;

  always_comb begin
    req_rd_d  = req_rd_q;
    req_wr_d  = req_wr_q;
    addr_hi_d = addr_hi_q;
    err_d     = err_q;
    if (state_q == IDLE) begin
      if (req) begin
        req_rd_d  = pmem_read;
        req_wr_d  = pmem_write;
        addr_hi_d = pmem_address[ADDR_WIDTH-1:4];
        if (pmem_read && pmem_write) err_d = 1'b1;
      end
    end else if ((pmem_read != req_rd_q) || (pmem_write != req_wr_q) ||
                 (pmem_address[ADDR_WIDTH-1:4] != addr_hi_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rd_q  <= 1'b0;
      req_wr_q  <= 1'b0;
      addr_hi_q <= '0;
      err_q     <= 1'b0;
    end else begin
      req_rd_q  <= req_rd_d;
      req_wr_q  <= req_wr_d;
      addr_hi_q <= addr_hi_d;
      err_q     <= err_d;
    end
  end

  assign protocol_err = err_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule
